// File: rtl/lfsr_pkg.sv
// Shared types, default polynomials and the single-shift helper for the LFSR keystream generator.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } fsm_t;

    // Widest state the shift helper supports; narrower states are zero-extended.
    localparam int MAX_W = 64;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [7:0]  SEED_8  = 8'hFA;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [15:0] SEED_16 = 16'hACE1;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [31:0] SEED_32 = 32'hDEAD_BEEF;

    function automatic logic [MAX_W-1:0] lfsr_shift(input logic [MAX_W-1:0] s,
                                                    input logic [MAX_W-1:0] taps,
                                                    input int w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        return {s[MAX_W-2:0], ^(s & taps)} & mask;
    endfunction

endpackage

// File: rtl/lfsr_keystream_gen_if.sv
// Keystream word handshake: generator drives value/out_valid, consumer drives out_ready.
interface lfsr_keystream_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] value;
    logic             out_valid;
    logic             out_ready;

    modport master (output value, output out_valid, input out_ready);
    modport slave  (input value, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_stepper.sv
// Combinational advance of a Fibonacci LFSR by STEP shifts.
module lfsr_stepper
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
    parameter int               STEP  = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] chain [STEP+1];

    assign chain[0] = cur;

    for (genvar i = 0; i < STEP; i++) begin : g_shift
        assign chain[i+1] = WIDTH'(lfsr_shift(MAX_W'(chain[i]), MAX_W'(TAPS), WIDTH));
    end

    assign nxt = chain[STEP];

endmodule

// File: rtl/lfsr_keystream_gen.sv
// Parametrised LFSR keystream source with warm-up, runtime seeding and ready/valid output.
// Optional macro RNG_ZERO_SEED_GUARD_EN: substitutes DEFAULT_SEED for a zero seed and pulses lockup_err.
module lfsr_keystream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_8),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(SEED_8),
    parameter int               WARMUP       = 10,
    parameter int               STEP         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    lfsr_keystream_gen_if.master ks,
    output logic                 rdy_random,
    output logic                 busy,
    output logic                 lockup_err
);

    // A zero-length warm-up still needs a one-bit counter to hold the value 0.
    localparam int               CNT_W    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP);

    fsm_t             fsm;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] shift_one;
    logic [WIDTH-1:0] shift_step;
    logic [WIDTH-1:0] load_val;
    logic             valid;
    logic             fire;

    lfsr_stepper #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(1)) u_warm_step (
        .cur (state),
        .nxt (shift_one)
    );

    lfsr_stepper #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(STEP)) u_word_step (
        .cur (state),
        .nxt (shift_step)
    );

    assign fire         = valid & ks.out_ready;
    assign ks.value     = state;
    assign ks.out_valid = valid;

`ifdef RNG_ZERO_SEED_GUARD_EN
    logic seed_zero;

    assign seed_zero = (seed == '0);
    assign load_val  = seed_zero ? DEFAULT_SEED : seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lockup_err <= 1'b0;
        end else if (ena) begin
            lockup_err <= seed_load & seed_zero;
        end
    end
`else
    assign load_val   = seed;
    assign lockup_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= DEFAULT_SEED;
            fsm        <= ST_IDLE;
            cnt        <= CNT_INIT;
            valid      <= 1'b0;
            rdy_random <= 1'b0;
            busy       <= 1'b0;
        end else if (ena) begin
            if (seed_load) begin
                state      <= load_val;
                fsm        <= ST_IDLE;
                cnt        <= CNT_INIT;
                valid      <= 1'b0;
                rdy_random <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (fsm)
                    ST_IDLE: begin
                        if (start) begin
                            fsm  <= ST_WARMUP;
                            busy <= 1'b1;
                        end
                    end
                    ST_WARMUP: begin
                        if (!start) begin
                            fsm  <= ST_IDLE;
                            cnt  <= CNT_INIT;
                            busy <= 1'b0;
                        end else if (cnt != '0) begin
                            state <= shift_one;
                            cnt   <= cnt - CNT_W'(1);
                        end else begin
                            fsm        <= ST_RUN;
                            valid      <= 1'b1;
                            rdy_random <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // A handshake on the stop cycle still consumes the current word.
                        if (fire) begin
                            state <= shift_step;
                        end
                        if (!start) begin
                            fsm        <= ST_IDLE;
                            cnt        <= CNT_INIT;
                            valid      <= 1'b0;
                            rdy_random <= 1'b0;
                        end
                    end
                    default: begin
                        fsm <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Self-checking bench: two generators (STEP=1 and STEP=2, WARMUP=2) driven from shared stimulus.
module tb_lfsr_keystream_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       seed_load;
    logic [7:0] seed;
    logic       out_ready;
    logic       rdy_a, busy_a, lerr_a;
    logic       rdy_b, busy_b, lerr_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] first;
        int         nwords;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];

    always #5 clk = ~clk;

    lfsr_keystream_gen_if #(.WIDTH(8)) ks_a ();
    lfsr_keystream_gen_if #(.WIDTH(8)) ks_b ();

    assign ks_a.out_ready = out_ready;
    assign ks_b.out_ready = out_ready;

    lfsr_keystream_gen #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'hFA), .WARMUP(2), .STEP(1)) dut_a (
        .clk(clk), .rst(rst_n), .ena(ena), .start(start), .seed_load(seed_load), .seed(seed),
        .ks(ks_a), .rdy_random(rdy_a), .busy(busy_a), .lockup_err(lerr_a)
    );

    lfsr_keystream_gen #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'hFA), .WARMUP(2), .STEP(2)) dut_b (
        .clk(clk), .rst(rst_n), .ena(ena), .start(start), .seed_load(seed_load), .seed(seed),
        .ks(ks_b), .rdy_random(rdy_b), .busy(busy_b), .lockup_err(lerr_b)
    );

    function automatic logic [7:0] mshift(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ks_a.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic load(input logic [7:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         budget;
        logic [7:0] s;
        logic [7:0] e;

        vecs[0] = '{seed: 8'hFA, first: 8'hE9, nwords: 4};
        vecs[1] = '{seed: 8'h01, first: 8'h04, nwords: 3};
        vecs[2] = '{seed: 8'h80, first: 8'h02, nwords: 3};
        vecs[3] = '{seed: 8'hFF, first: 8'hFC, nwords: 5};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 8'h00; out_ready = 1'b0;
        #12;
        chk8("rst_value", ks_a.value, 8'hFA);
        chk1("rst_valid", ks_a.out_valid, 1'b0);
        chk1("rst_rdy", rdy_a, 1'b0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_lockup", lerr_a, 1'b0);
        tick();
        rst_n = 1'b1;

        // Default seed, STEP 1 and STEP 2 sequences
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        chk1("t1_busy", busy_a, 1'b1);
        chk1("t1_valid_early", ks_a.out_valid, 1'b0);
        tick();
        tick();
        chk1("t1_valid_w2", ks_a.out_valid, 1'b0);
        tick();
        chk1("t1_valid", ks_a.out_valid, 1'b1);
        chk1("t1_rdy", rdy_a, 1'b1);
        chk1("t1_busy_off", busy_a, 1'b0);
        chk8("t1_w0", ks_a.value, 8'hE9);
        chk8("t2_w0", ks_b.value, 8'hE9);
        tick();
        chk8("t1_w1", ks_a.value, 8'hD3);
        chk8("t2_w1", ks_b.value, 8'hA6);
        tick();
        chk8("t1_w2", ks_a.value, 8'hA6);
        start = 1'b0;
        tick();

        // Table rows: reseed, re-warm, scoreboard the words from both generators
        foreach (vecs[r]) begin
            start = 1'b0;
            load(vecs[r].seed);
            chk8("tbl_load", ks_a.value, vecs[r].seed);
            chk1("tbl_lockup", lerr_a, 1'b0);
            s = vecs[r].seed;
            s = mshift(mshift(s));
            for (int k = 0; k < vecs[r].nwords; k++) begin
                q_a.push_back(s);
                s = mshift(s);
            end
            s = mshift(mshift(vecs[r].seed));
            for (int k = 0; k < vecs[r].nwords; k++) begin
                q_b.push_back(s);
                s = mshift(mshift(s));
            end
            start = 1'b1;
            wait_valid(lat);
            chki("tbl_latency", lat, 4);
            chk8("tbl_first", ks_a.value, vecs[r].first);
            chk1("tbl_rdy_b", rdy_b, 1'b1);
            budget = 0;
            while ((q_a.size() > 0 || q_b.size() > 0) && budget < 30) begin
                if (ks_a.out_valid && q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk8("sb_a", ks_a.value, e);
                end
                if (ks_b.out_valid && q_b.size() > 0) begin
                    e = q_b.pop_front();
                    chk8("sb_b", ks_b.value, e);
                end
                tick();
                budget++;
            end
            chki("sb_drain", q_a.size() + q_b.size(), 0);
            q_a.delete();
            q_b.delete();
        end
        start = 1'b0;
        tick();

        // Backpressure and clock-enable hold
        out_ready = 1'b0;
        load(8'hFA);
        start = 1'b1;
        wait_valid(lat);
        chki("t3_latency", lat, 4);
        chk8("t3_first", ks_a.value, 8'hE9);
        repeat (5) tick();
        chk8("t3_stall", ks_a.value, 8'hE9);
        chk1("t3_stall_valid", ks_a.out_valid, 1'b1);
        ena       = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk8("t3_ena_hold", ks_a.value, 8'hE9);
        chk1("t3_ena_valid", ks_a.out_valid, 1'b1);
        ena = 1'b1;
        tick();
        chk8("t3_advance", ks_a.value, 8'hD3);
        start = 1'b0;
        tick();

        // Warm-up abort keeps partial state; restarts re-warm fully
        load(8'hFA);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        chk1("ab_busy", busy_a, 1'b0);
        chk8("ab_partial", ks_a.value, 8'hF4);
        start = 1'b1;
        wait_valid(lat);
        chki("ab_latency", lat, 4);
        chk8("ab_value", ks_a.value, 8'hD3);
        start = 1'b0;
        tick();
        chk8("stop_advance", ks_a.value, 8'hA6);
        chk1("stop_valid", ks_a.out_valid, 1'b0);
        chk1("stop_rdy", rdy_a, 1'b0);
        start = 1'b1;
        wait_valid(lat);
        chki("rewarm_latency", lat, 4);
        chk8("rewarm_value", ks_a.value, 8'h99);

        // Reseed during RUN with start held
        load(8'h01);
        chk1("t4_valid", ks_a.out_valid, 1'b0);
        chk1("t4_rdy", rdy_a, 1'b0);
        chk8("t4_state", ks_a.value, 8'h01);
        wait_valid(lat);
        chki("t4_latency", lat, 4);
        chk8("t4_value", ks_a.value, 8'h04);

        // Asynchronous reset mid-warm-up
        start = 1'b0;
        load(8'hFA);
        start = 1'b1;
        tick();
        chk1("t5_busy_pre", busy_a, 1'b1);
        tick();
        chk8("t5_pre", ks_a.value, 8'hF4);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("t5_value", ks_a.value, 8'hFA);
        chk1("t5_valid", ks_a.out_valid, 1'b0);
        chk1("t5_rdy", rdy_a, 1'b0);
        chk1("t5_busy", busy_a, 1'b0);
        chk1("t5_busy_b", busy_b, 1'b0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk8("t5_after", ks_a.value, 8'hFA);

        // Zero seed
        load(8'h00);
`ifdef RNG_ZERO_SEED_GUARD_EN
        chk8("t6_subst", ks_a.value, 8'hFA);
        chk1("t6_lockup", lerr_a, 1'b1);
        chk1("t6_lockup_b", lerr_b, 1'b1);
        tick();
        chk1("t6_lockup_clr", lerr_a, 1'b0);
`else
        chk8("t6_zero", ks_a.value, 8'h00);
        chk1("t6_lockup", lerr_a, 1'b0);
        chk1("t6_lockup_b", lerr_b, 1'b0);
        start = 1'b1;
        wait_valid(lat);
        chki("t6_latency", lat, 4);
        chk8("t6_run", ks_a.value, 8'h00);
        tick();
        chk8("t6_locked", ks_a.value, 8'h00);
        chk1("t6_valid", ks_a.out_valid, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_keystream_gen.md
Name: lfsr_keystream_gen

Overview:
Parametrised Fibonacci-LFSR keystream source for the C&C/terminal encryption link. It generalises the 8-bit generator with the following additions:
- configurable width, tap mask, seed and warm-up length;
- runtime seed loading;
- multi-step advance per word;
- a ready/valid output handshake, so the cipher datapath can pull keystream words at its own rate.

Parameters:
WIDTH, 8, LFSR/state and output word width (>=3)
TAPS, 8'hB8, feedback tap mask; bit i set => state[i] enters XOR; MSB must be set
DEFAULT_SEED, 8'hFA, reset/substitute seed (WIDTH bits, nonzero)
WARMUP, 10, number of discarded shifts after start (0 allowed)
STEP, 1, shifts per accepted output word (1..WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
ena  in  1  clock enable; when 0 all registers hold
start  in  1  level: 1 = run generator, 0 = stop and return to IDLE
seed_load  in  1  load seed into state (one enabled cycle)
seed  in  WIDTH  seed value for seed_load
out_ready  in  1  consumer accepts value this cycle
value  out  WIDTH  current keystream word (= state)
out_valid  out  1  value is valid keystream
rdy_random  out  1  level: warm-up complete, generator in RUN
busy  out  1  in WARMUP
lockup_err  out  1  one-cycle pulse on zero-seed substitution (macro only; else tied 0)

Behaviour:
- Reset (rst=0, async): state=DEFAULT_SEED, fsm=IDLE, cnt=WARMUP, out_valid=0, rdy_random=0, busy=0, lockup_err=0.
- Feedback: fb = XOR-reduce(state & TAPS); one shift: state <= {state[WIDTH-2:0], fb}. STEP shifts in one cycle are computed combinationally.
- All transitions below require ena=1. With ena=0 nothing changes and out_valid holds.
- seed_load has the highest priority in every state:
  - state <= seed, fsm -> IDLE, cnt <= WARMUP, out_valid <= 0.
  - Any handshake in the same cycle is discarded.
- IDLE:
  - start=1 -> WARMUP, busy=1.
  - state holds.
- WARMUP:
  - If cnt!=0: shift once, cnt--.
  - If cnt==0: -> RUN, out_valid=1, rdy_random=1, busy=0; no shift on that cycle.
  - Exactly WARMUP shifts are performed; first out_valid appears WARMUP+1 enabled cycles after start is sampled.
  - start=0 -> IDLE, cnt<=WARMUP; the partial warm-up is kept in state.
- RUN:
  - value=state; out_valid=1.
  - Handshake (out_valid & out_ready) -> state advances STEP shifts; the new word is visible the next cycle.
  - Without a handshake, value is stable.
  - start=0 -> IDLE, out_valid=0, rdy_random=0. A simultaneous handshake still advances state.
  - cnt is reloaded to WARMUP on leaving RUN, so a restart re-warms.
- Wrap-around: the sequence period is a property of TAPS and is not checked. cnt is $clog2(WARMUP+1) bits and never underflows.
- Reset mid-operation: all outputs return to reset values immediately, and the sequence restarts from DEFAULT_SEED.

Optional Feature:
RNG_ZERO_SEED_GUARD_EN
- Defined: a seed_load with seed==0 loads DEFAULT_SEED instead, and lockup_err pulses high for one cycle.
- Undefined: the seed is loaded verbatim and lockup_err is tied 0. A zero seed locks state at 0, and value=0 is still output with out_valid per the normal FSM.

Decomposition:
- Package lfsr_pkg holds:
  - the FSM state typedef (IDLE, WARMUP, RUN);
  - default TAPS/DEFAULT_SEED constants for 8/16/32 widths;
  - the single-shift function.
- One natural sub-module: lfsr_stepper, a combinational STEP-shift advance parametrised by WIDTH, TAPS and STEP.

Test Plan:
1. Defaults with WARMUP=2, STEP=1, out_ready=1, start=1 -> value sequence E9, D3, A6; out_valid first high 3 cycles after start.
2. WARMUP=2, STEP=2, out_ready=1 -> first value E9, next A6.
3. RUN with out_ready=0 for 5 cycles -> value stays E9; ena=0 for 3 cycles with out_ready=1 -> no advance.
4. seed_load seed=8'h01 during RUN -> out_valid drops next cycle, fsm IDLE, state=01; start held -> re-warm WARMUP shifts before out_valid.
5. rst=0 asynchronously mid-WARMUP -> out_valid/rdy_random/busy 0 immediately, value=FA.
6. seed_load seed=0: with macro -> value=FA, lockup_err single pulse; without -> value stays 00 in RUN.
